// File: rtl/mult_matrix_deskew.sv
// Re-aligns the diagonal wavefront from the systolic array into one parallel vector.
// Latency: size cycles from lane 0 to registered output. No backpressure; one vector per cycle.
// Lane r waits size-1-r cycles so every lane of a wavefront meets in the same cycle.
module mult_matrix_deskew #(
    parameter int data_size   = 4,
    parameter int size        = 3,
    parameter int count_width = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [data_size*size-1:0] input_stream,
    output logic [data_size*size-1:0] output_stream,
    output logic                      out_valid,
    output logic [count_width-1:0]    vec_count
);

    localparam int W = data_size * size;

    logic [W-1:0]    aligned;
    logic [size-1:0] vld_pipe;
    logic [size-1:0] vld_next;
    logic            load;

    generate
        for (genvar r = 0; r < size; r++) begin : g_lane
            localparam int DEPTH = size - 1 - r;
            localparam int HI    = (size - r) * data_size - 1;
            if (DEPTH == 0) begin : g_pass
                assign aligned[HI -: data_size] = input_stream[HI -: data_size];
            end else begin : g_dly
                logic [data_size-1:0] dly [DEPTH];
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
                    end else if (clear) begin
                        for (int i = 0; i < DEPTH; i++) dly[i] <= '0;
                    end else begin
                        dly[0] <= input_stream[HI -: data_size];
                        for (int i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
                    end
                end
                assign aligned[HI -: data_size] = dly[DEPTH-1];
            end
        end

        // The stage one short of the tap marks the cycle the lanes are aligned.
        if (size == 1) begin : g_v1
            assign vld_next = in_valid;
            assign load     = in_valid;
        end else begin : g_vn
            assign vld_next = {vld_pipe[size-2:0], in_valid};
            assign load     = vld_pipe[size-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe <= '0;
        else if (clear)
            vld_pipe <= '0;
        else
            vld_pipe <= vld_next;
    end

    assign out_valid = vld_pipe[size-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            output_stream <= '0;
        else if (load && !clear)
            output_stream <= aligned;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vec_count <= '0;
        else if (clear)
            vec_count <= '0;
        else if (out_valid)
            vec_count <= vec_count + 1'b1;
    end

endmodule

// File: tb/tb_mult_matrix_deskew.sv
// Bench for mult_matrix_deskew: directed wavefronts plus random traffic against a cycle-history model.
module tb_mult_matrix_deskew;
    localparam int DS = 4;
    localparam int SZ = 3;
    localparam int W  = DS * SZ;
    localparam int N  = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] input_stream = '0;
    logic [W-1:0] output_stream, output_stream2;
    logic         out_valid, out_valid2;
    logic [7:0]   vec_count;
    logic [1:0]   vec_count2;

    mult_matrix_deskew #(.data_size(DS), .size(SZ), .count_width(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .input_stream(input_stream), .output_stream(output_stream),
        .out_valid(out_valid), .vec_count(vec_count));

    mult_matrix_deskew #(.data_size(DS), .size(SZ), .count_width(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .input_stream(input_stream), .output_stream(output_stream2),
        .out_valid(out_valid2), .vec_count(vec_count2));

    always #5 clk = ~clk;

    // Per-cycle history: what was started, accepted, flushed.
    bit           stv  [N];
    bit           acc  [N];
    bit           clrf [N];
    bit           rstf [N];
    logic [W-1:0] vd   [N];
    int           cyc = -1;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DS-1:0] lane_of(input logic [W-1:0] v, input int r);
        return v[(SZ-r)*DS-1 -: DS];
    endfunction

    task automatic step(input bit iv, input logic [W-1:0] v, input bit clr);
        @(posedge clk);
        #1;
        cyc++;
        stv[cyc]  = iv;
        vd[cyc]   = v;
        clrf[cyc] = clr;
        rstf[cyc] = rst;
        acc[cyc]  = iv && !clr && !rst;
        in_valid  = iv;
        clear     = clr;
        for (int r = 0; r < SZ; r++) begin
            if (cyc - r >= 0 && stv[cyc-r])
                input_stream[(SZ-r)*DS-1 -: DS] = lane_of(vd[cyc-r], r);
            else
                input_stream[(SZ-r)*DS-1 -: DS] = DS'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b0);
    endtask

    task automatic rpulse();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        rstf[cyc] = 1'b1;
    endtask

    // Model: a vector started at t0 emits at t0+SZ unless a clear lands in
    // [t0, t0+SZ-1] or a reset lands in (t0, t0+SZ].
    int           mcnt  = 0;
    logic [W-1:0] mlast = '0;

    always @(negedge clk) begin
        if (cyc >= 0) begin
            bit ev;
            int t0;
            ev = 1'b0;
            t0 = cyc - SZ;
            if (t0 >= 0 && acc[t0]) begin
                ev = 1'b1;
                for (int k = t0; k < cyc; k++) if (clrf[k]) ev = 1'b0;
                for (int k = t0 + 1; k <= cyc; k++) if (rstf[k]) ev = 1'b0;
            end
            if (rstf[cyc]) begin
                mcnt  = 0;
                mlast = '0;
            end else if (ev) begin
                mlast = vd[t0];
            end
            chk("out_valid", 32'(out_valid), 32'(ev));
            chk("output_stream", 32'(output_stream), 32'(mlast));
            chk("vec_count", 32'(vec_count), 32'(mcnt % 256));
            chk("out_valid_w2", 32'(out_valid2), 32'(ev));
            chk("output_stream_w2", 32'(output_stream2), 32'(mlast));
            chk("vec_count_w2", 32'(vec_count2), 32'(mcnt % 4));
            if (ev) mcnt++;
            if (clrf[cyc]) mcnt = 0;
        end
    end

    logic [W-1:0] vec6 [5] = '{12'h321, 12'h654, 12'h987, 12'hCBA, 12'hFED};
    logic [1:0]   cnt6 [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        // Reset with random inputs, then quiet release.
        step(1'($urandom), W'($urandom), 1'($urandom));
        @(negedge clk);
        chk("rst_out", 32'(output_stream), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(vec_count), 32'h0);
        step(1'($urandom), W'($urandom), 1'($urandom));
        @(negedge clk);
        rst = 1'b0;
        idle(10);

        // Single wavefront 1,2,3.
        step(1'b1, 12'h123, 1'b0);
        idle(3);
        @(negedge clk);
        chk("t2_valid", 32'(out_valid), 32'h1);
        chk("t2_out", 32'(output_stream), 32'h123);
        idle(1);
        @(negedge clk);
        chk("t2_pulse", 32'(out_valid), 32'h0);
        chk("t2_count", 32'(vec_count), 32'h1);

        // Three back-to-back wavefronts.
        step(1'b0, '0, 1'b1);
        step(1'b1, 12'h123, 1'b0);
        step(1'b1, 12'h456, 1'b0);
        step(1'b1, 12'h789, 1'b0);
        idle(1);
        @(negedge clk);
        chk("t3_v0", 32'(output_stream), 32'h123);
        idle(1);
        @(negedge clk);
        chk("t3_v1", 32'(output_stream), 32'h456);
        idle(1);
        @(negedge clk);
        chk("t3_v2", 32'(output_stream), 32'h789);
        chk("t3_valid", 32'(out_valid), 32'h1);
        idle(1);
        @(negedge clk);
        chk("t3_count", 32'(vec_count), 32'h3);

        // Narrow counter wrap over five back-to-back vectors.
        step(1'b0, '0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            step(k < 5, (k < 5) ? vec6[k] : W'($urandom), 1'b0);
            if (k >= 4) begin
                @(negedge clk);
                chk("t6_count_w2", 32'(vec_count2), 32'(cnt6[k-4]));
            end
        end

        // Clear flushes an in-flight vector; a later one still emits.
        step(1'b1, 12'h5A5, 1'b0);
        step(1'b1, 12'h777, 1'b1);
        step(1'b1, 12'hABC, 1'b0);
        @(negedge clk);
        chk("t4_count", 32'(vec_count), 32'h0);
        idle(1);
        @(negedge clk);
        chk("t4_hold", 32'(output_stream), 32'hFED);
        chk("t4_novalid", 32'(out_valid), 32'h0);
        idle(2);
        @(negedge clk);
        chk("t4_valid", 32'(out_valid), 32'h1);
        chk("t4_out", 32'(output_stream), 32'hABC);
        idle(8);

        // Async reset mid-wavefront.
        step(1'b1, 12'h3C9, 1'b0);
        idle(2);
        rpulse();
        @(negedge clk);
        chk("t5_out", 32'(output_stream), 32'h0);
        chk("t5_count", 32'(vec_count), 32'h0);
        idle(1);
        @(negedge clk);
        chk("t5_novalid", 32'(out_valid), 32'h0);
        idle(6);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 4);
            if ($urandom_range(0, 199) == 0) rpulse();
        end
        idle(6);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
